// File: rtl/receive.sv
// UART receive engine: 2-flop Rx synchroniser, bit-centre sampling FSM and
// processor-facing data/status registers (RxRDY, perr, ferr, ovf).
module receive #(
  parameter int unsigned K_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Rx,
  input  logic [K_W-1:0] k,
  input  logic           eight,
  input  logic           parity_en,
  input  logic           ohel,
  input  logic           clr_rdy,
  output logic [7:0]     data,
  output logic           RxRDY,
  output logic           perr,
  output logic           ferr,
  output logic           ovf
);

  localparam int unsigned BC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_LATCH
  } state_t;

  state_t          state_q, state_d;
  logic            rx_m_q, rx_s_q;
  logic [K_W-1:0]  btc_q, btc_d;
  logic [BC_W-1:0] bitcnt_q, bitcnt_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
  logic [7:0]      sh_q, sh_d;
  logic            pbit_q, pbit_d, stop_q, stop_d;
  logic            line_hi_q, line_hi_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  logic            full_c, half_c;
  logic [7:0]      byte_c;

  assign full_c = (btc_q == k_q);
  assign half_c = (btc_q == (k_q >> 1));
  // 7-bit frames land in sh_q[7:1]; right-align with data[7]=0
  assign byte_c = eight_q ? sh_q : {1'b0, sh_q[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      btc_q     <= '0;
      bitcnt_q  <= '0;
      k_q       <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      sh_q      <= '0;
      pbit_q    <= 1'b0;
      stop_q    <= 1'b1;
      line_hi_q <= 1'b1;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_m_q    <= Rx;
      rx_s_q    <= rx_m_q;
      state_q   <= state_d;
      btc_q     <= btc_d;
      bitcnt_q  <= bitcnt_d;
      k_q       <= k_d;
      eight_q   <= eight_d;
      pen_q     <= pen_d;
      ohel_q    <= ohel_d;
      sh_q      <= sh_d;
      pbit_q    <= pbit_d;
      stop_q    <= stop_d;
      line_hi_q <= line_hi_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    btc_d     = btc_q;
    bitcnt_d  = bitcnt_q;
    k_d       = k_q;
    eight_d   = eight_q;
    pen_d     = pen_q;
    ohel_d    = ohel_q;
    sh_d      = sh_q;
    pbit_d    = pbit_q;
    stop_d    = stop_q;
    line_hi_d = line_hi_q | rx_s_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;

    if (clr_rdy) begin
      rdy_d = 1'b0;
      ovf_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        btc_d    = '0;
        bitcnt_d = '0;
        // line_hi_q blocks retrigger while a break holds the line low
        if (!rx_s_q && line_hi_q) begin
          state_d = S_START;
          k_d     = k;
          eight_d = eight;
          pen_d   = parity_en;
          ohel_d  = ohel;
        end
      end
      S_START: begin
        if (half_c) begin
          btc_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          btc_d = btc_q + K_W'(1);
        end
      end
      S_DATA: begin
        if (full_c) begin
          btc_d    = '0;
          sh_d     = {rx_s_q, sh_q[7:1]};
          bitcnt_d = bitcnt_q + BC_W'(1);
          if (bitcnt_q == (eight_q ? BC_W'(7) : BC_W'(6)))
            state_d = pen_q ? S_PARITY : S_STOP;
        end else begin
          btc_d = btc_q + K_W'(1);
        end
      end
      S_PARITY: begin
        if (full_c) begin
          btc_d   = '0;
          pbit_d  = rx_s_q;
          state_d = S_STOP;
        end else begin
          btc_d = btc_q + K_W'(1);
        end
      end
      S_STOP: begin
        if (full_c) begin
          btc_d   = '0;
          stop_d  = rx_s_q;
          state_d = S_LATCH;
        end else begin
          btc_d = btc_q + K_W'(1);
        end
      end
      S_LATCH: begin
        data_d  = byte_c;
        perr_d  = pen_q & (pbit_q != ((^byte_c) ^ ohel_q));
        ferr_d  = ~stop_q;
        rdy_d   = 1'b1;
        ovf_d   = clr_rdy ? 1'b0 : (ovf_q | rdy_q);
        state_d = S_IDLE;
        if (!stop_q) line_hi_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data  = data_q;
  assign RxRDY = rdy_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_receive.sv
// Self-checking bench for receive: serial frames are driven bit by bit, expected
// results are queued at drive time and compared when the DUT completes a frame.
module tb_receive;

  localparam int unsigned K_W = 19;
  localparam int BIT_CLKS = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           Rx = 1'b1;
  logic [K_W-1:0] k = K_W'(9);
  logic           eight = 1'b1, parity_en = 1'b0, ohel = 1'b0, clr_rdy = 1'b0;
  logic [7:0]     data;
  logic           RxRDY, perr, ferr, ovf;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_rdy = 1'b0, m_ovf = 1'b0;

  receive #(.K_W(K_W)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .k(k), .eight(eight),
    .parity_en(parity_en), .ohel(ohel), .clr_rdy(clr_rdy),
    .data(data), .RxRDY(RxRDY), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one frame; optionally pulse clr_rdy on the DUT's completion cycle
  task automatic send_frame(input logic [7:0] b, input logic e8, input logic pen,
                            input logic odd, input logic pbit, input logic stopb,
                            input logic clr_done);
    logic [11:0] bits;
    int   nd, np, nb, done_cyc;
    exp_t e;
    nd = e8 ? 8 : 7;
    np = pen ? 1 : 0;
    nb = nd + np + 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1+i] = b[i];
    if (pen) bits[1+nd] = pbit;
    bits[nb-1] = stopb;
    done_cyc = 18 + BIT_CLKS * (nd + np);
    eight = e8; parity_en = pen; ohel = odd;
    e.data = e8 ? b : {1'b0, b[6:0]};
    e.perr = pen & (pbit != ((^e.data) ^ odd));
    e.ferr = ~stopb;
    e.ovf  = clr_done ? 1'b0 : (m_ovf | m_rdy);
    exp_q.push_back(e);
    m_rdy = 1'b1;
    m_ovf = e.ovf;
    for (int cyc = 0; cyc < nb * BIT_CLKS; cyc++) begin
      @(posedge clk);
      Rx = bits[cyc / BIT_CLKS];
      clr_rdy = clr_done && (cyc == done_cyc);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); clr_rdy = 1'b1;
    @(posedge clk); clr_rdy = 1'b0;
    m_rdy = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    check("clr_rdy_RxRDY", RxRDY, 0);
    check("clr_rdy_ovf", ovf, 0);
  endtask

  // Monitor: a completion is RxRDY rising, or new data/ovf while RxRDY held
  initial begin
    logic [7:0] p_data;
    logic p_rdy, p_ovf;
    exp_t e;
    p_data = '0; p_rdy = 1'b0; p_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && RxRDY && (!p_rdy || data != p_data || (ovf && !p_ovf))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", data, e.data);
          check("perr", perr, e.perr);
          check("ferr", ferr, e.ferr);
          check("ovf", ovf, e.ovf);
        end
      end
      p_data = data; p_rdy = RxRDY; p_ovf = ovf;
    end
  end

  initial begin
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_RxRDY", RxRDY, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 3-clk glitch must not produce a frame
    Rx = 1'b0;
    repeat (3) @(posedge clk);
    Rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_RxRDY", RxRDY, 0);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_clr();
    send_frame(8'hC5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pulse_clr();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr();

    // Framing error followed by a break: no retrigger while the line is low
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("break_pending", exp_q.size(), 0);
    check("break_RxRDY", RxRDY, 1);
    @(posedge clk); Rx = 1'b1;
    repeat (20) @(posedge clk);
    pulse_clr();

    // Overflow, then completion coinciding with clr_rdy
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    send_frame(8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h78, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("coincident_RxRDY", RxRDY, 1);
    pulse_clr();

    // Reset in the middle of the data bits
    @(posedge clk); Rx = 1'b0;
    repeat (25) @(posedge clk); Rx = 1'b1;
    repeat (10) @(posedge clk); Rx = 1'b0;
    repeat (10) @(posedge clk);
    rst = 1'b1;
    Rx = 1'b1;
    m_rdy = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_RxRDY", RxRDY, 0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
